// File: rtl/r_instr_pkg.sv
// Shared constants and types for the R-type instruction sequencer.
// ALU opcodes, MIPS funct codes, FSM states and the latched instruction fields.
package r_instr_pkg;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_XNOR = 3'b011;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLL  = 3'b111;

    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_SLLV = 6'b000100;

    localparam logic [5:0] OP_RTYPE = 6'b000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_e;

    // Only the fields the sequencer consumes; shamt is not kept.
    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [5:0] funct;
    } rinstr_t;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/r_instr_ctrl_if.sv
// Fetch/register-file/ALU signal bundle around the R-type sequencer.
// Optional R_INSTR_OF_TRAP_EN adds the ov_trap pulse.
interface r_instr_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int DW     = 32
);
    logic              instr_valid;
    logic [31:0]       instr;
    logic              instr_ready;
    logic [REG_AW-1:0] rf_ra;
    logic [REG_AW-1:0] rf_rb;
    logic [REG_AW-1:0] rf_wa;
    logic              rf_we;
    logic [DW-1:0]     rf_wd;
    logic [2:0]        alu_op;
    logic [DW-1:0]     alu_f;
    logic              alu_zf;
    logic              alu_of;
    logic              zf_q;
    logic              of_q;
    logic              done;
    logic              illegal;
`ifdef R_INSTR_OF_TRAP_EN
    logic              ov_trap;
`endif

    modport master (
`ifdef R_INSTR_OF_TRAP_EN
        output ov_trap,
`endif
        input  instr_valid, instr, alu_f, alu_zf, alu_of,
        output instr_ready, rf_ra, rf_rb, rf_wa, rf_we, rf_wd, alu_op,
        output zf_q, of_q, done, illegal
    );

    modport slave (
`ifdef R_INSTR_OF_TRAP_EN
        input  ov_trap,
`endif
        output instr_valid, instr, alu_f, alu_zf, alu_of,
        input  instr_ready, rf_ra, rf_rb, rf_wa, rf_we, rf_wd, alu_op,
        input  zf_q, of_q, done, illegal
    );

endinterface

// File: rtl/r_instr_decode.sv
// Combinational R-type decode: op/funct -> ALU opcode, illegal flag, write-back permission.
// Zero latency; undecodable words fall back to ALU_AND with writes disabled.
module r_instr_decode
    import r_instr_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic [4:0] rd_i,
    output logic [2:0] alu_op_o,
    output logic       illegal_o,
    output logic       wr_en_ok_o
);

    always_comb begin
        alu_op_o  = ALU_AND;
        illegal_o = 1'b0;
        if (op_i != OP_RTYPE) begin
            illegal_o = 1'b1;
        end else begin
            case (funct_i)
                FN_AND:  alu_op_o = ALU_AND;
                FN_OR:   alu_op_o = ALU_OR;
                FN_XOR:  alu_op_o = ALU_XOR;
                FN_NOR:  alu_op_o = ALU_XNOR;
                FN_ADD:  alu_op_o = ALU_ADD;
                FN_SUB:  alu_op_o = ALU_SUB;
                FN_SLTU: alu_op_o = ALU_SLTU;
                FN_SLLV: alu_op_o = ALU_SLL;
                default: illegal_o = 1'b1;
            endcase
        end
        // r0 is hardwired zero, so writes to it are dropped
        wr_en_ok_o = !illegal_o && (rd_i != 5'd0);
    end

endmodule

// File: rtl/r_instr_ctrl.sv
// Four-cycle R-type sequencer: accept, decode, execute, write back (optional R_INSTR_OF_TRAP_EN).
// Handshake to done is 4 cycles inclusive; instr_ready is low while an instruction is in flight.
module r_instr_ctrl
    import r_instr_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int DW     = 32
) (
    input  logic           clk,
    input  logic           rst,
    r_instr_ctrl_if.master bus
);

    state_e        state_q, state_d;
    rinstr_t       instr_q, instr_d;
    logic          illegal_q, illegal_d;
    logic          wr_ok_q, wr_ok_d;
    logic          zf_q, zf_d;
    logic          of_q, of_d;
    logic          trap_q, trap_d;
    logic [DW-1:0] rf_wd_q, rf_wd_d;

    logic [2:0]    dec_alu_op;
    logic          dec_illegal;
    logic          dec_wr_ok;

    logic          instr_ready_c, rf_we_c, done_c, illegal_c, trap_c;

    r_instr_decode u_decode (
        .op_i       (instr_q.op),
        .funct_i    (instr_q.funct),
        .rd_i       (instr_q.rd),
        .alu_op_o   (dec_alu_op),
        .illegal_o  (dec_illegal),
        .wr_en_ok_o (dec_wr_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        instr_ready_c = 1'b0;
        rf_we_c       = 1'b0;
        done_c        = 1'b0;
        illegal_c     = 1'b0;
        trap_c        = 1'b0;
        case (state_q)
            IDLE: begin
                instr_ready_c = 1'b1;
                if (bus.instr_valid) state_d = DECODE;
            end
            DECODE: state_d = EXEC;
            EXEC:   state_d = WB;
            WB: begin
                state_d   = IDLE;
                done_c    = 1'b1;
                rf_we_c   = wr_ok_q && !trap_q;
                illegal_c = illegal_q;
                trap_c    = trap_q;
            end
            default: state_d = IDLE;
        endcase
        // Reset wins even in the WB cycle: no write may escape an abort.
        if (rst) begin
            rf_we_c   = 1'b0;
            done_c    = 1'b0;
            illegal_c = 1'b0;
            trap_c    = 1'b0;
        end
    end

    always_comb begin
        instr_d   = instr_q;
        illegal_d = illegal_q;
        wr_ok_d   = wr_ok_q;
        zf_d      = zf_q;
        of_d      = of_q;
        trap_d    = trap_q;
        rf_wd_d   = rf_wd_q;
        case (state_q)
            IDLE: begin
                if (bus.instr_valid) begin
                    instr_d = {bus.instr[31:26], bus.instr[25:21], bus.instr[20:16],
                               bus.instr[15:11], bus.instr[5:0]};
                end
            end
            DECODE: begin
                illegal_d = dec_illegal;
                wr_ok_d   = dec_wr_ok;
            end
            EXEC: begin
                trap_d = 1'b0;
                if (!illegal_q) begin
                    rf_wd_d = bus.alu_f;
                    zf_d    = bus.alu_zf;
                    of_d    = is_arith(dec_alu_op) ? bus.alu_of : 1'b0;
`ifdef R_INSTR_OF_TRAP_EN
                    trap_d  = is_arith(dec_alu_op) && bus.alu_of;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q   <= '0;
            illegal_q <= 1'b0;
            wr_ok_q   <= 1'b0;
            zf_q      <= 1'b0;
            of_q      <= 1'b0;
            trap_q    <= 1'b0;
            rf_wd_q   <= '0;
        end else begin
            instr_q   <= instr_d;
            illegal_q <= illegal_d;
            wr_ok_q   <= wr_ok_d;
            zf_q      <= zf_d;
            of_q      <= of_d;
            trap_q    <= trap_d;
            rf_wd_q   <= rf_wd_d;
        end
    end

    // Datapath addresses and opcode follow instr_q, so they stay put while idle.
    assign bus.instr_ready = instr_ready_c;
    assign bus.rf_ra       = REG_AW'(instr_q.rs);
    assign bus.rf_rb       = REG_AW'(instr_q.rt);
    assign bus.rf_wa       = REG_AW'(instr_q.rd);
    assign bus.rf_we       = rf_we_c;
    assign bus.rf_wd       = rf_wd_q;
    assign bus.alu_op      = dec_alu_op;
    assign bus.zf_q        = zf_q;
    assign bus.of_q        = of_q;
    assign bus.done        = done_c;
    assign bus.illegal     = illegal_c;
`ifdef R_INSTR_OF_TRAP_EN
    assign bus.ov_trap     = trap_c;
`endif

endmodule

// File: doc/r_instr_ctrl.md
Name: r_instr_ctrl

Overview:
- Multi-cycle sequencer for MIPS R-type instructions.
- Accepts one 32-bit instruction per handshake, decodes opcode/funct into the 3-bit ALU opcode, and drives register-file read addresses.
- Latches ALU result and flags, then issues one register-file write.
- Sits between the instruction fetch stage and the register file / ALU pair in the R-type datapath.

Parameters:
- REG_AW, 5, register-file address width.
- DW, 32, data width of ALU operands/result.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- instr_valid  in  1  instruction word present.
- instr  in  32  instruction word: [31:26] op, [25:21] rs, [20:16] rt, [15:11] rd, [5:0] funct.
- instr_ready  out  1  controller idle, can accept instruction.
- rf_ra  out  REG_AW  register-file read port A address (rs).
- rf_rb  out  REG_AW  register-file read port B address (rt).
- rf_wa  out  REG_AW  register-file write address (rd).
- rf_we  out  1  register-file write enable, one-cycle pulse.
- rf_wd  out  DW  write data (latched ALU result).
- alu_op  out  3  ALU opcode to datapath.
- alu_f  in  DW  ALU result.
- alu_zf  in  1  ALU zero flag.
- alu_of  in  1  ALU overflow flag.
- zf_q  out  1  latched zero flag of last executed instruction.
- of_q  out  1  latched overflow flag of last executed instruction.
- done  out  1  one-cycle pulse at end of each accepted instruction.
- illegal  out  1  one-cycle pulse, coincident with done, for undecodable instruction.

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0 except instr_ready=1; internal instruction register cleared.
- FSM states and transitions:
  - IDLE: instr_ready=1. On instr_valid&instr_ready, latch instr -> DECODE.
  - DECODE: drive rf_ra=rs, rf_rb=rt. Decode funct -> alu_op; set internal illegal bit. -> EXEC.
  - EXEC: alu_op held stable (ALU combinational). Sample alu_f->rf_wd, alu_zf->zf_q, alu_of->of_q at end of cycle. -> WB.
  - WB: rf_wa=rd; rf_we=1 unless suppressed; done=1; illegal pulses if set. -> IDLE.
- Latency: 4 cycles from handshake to done inclusive; throughput 1 instruction per 4 cycles; instr_ready low in DECODE/EXEC/WB.
- Decode map (op must be 000000):
  - funct 100100 AND -> 000
  - funct 100101 OR -> 001
  - funct 100110 XOR -> 010
  - funct 100111 -> 011 (ALU XNOR)
  - funct 100000 ADD -> 100
  - funct 100010 SUB -> 101
  - funct 101011 SLTU -> 110
  - funct 000100 SLLV -> 111 (ALU computes B<<A; rs supplies A, rt supplies B)
- Illegal: op!=0 or funct unlisted.
  - alu_op=000; rf_we suppressed; zf_q/of_q unchanged; done and illegal pulse in WB.
- rd=0: rf_we suppressed (r0 hardwired zero); flags still updated; done pulses.
- rf_ra/rf_rb/rf_wa/alu_op hold their last values in IDLE (no glitching on the datapath).
- of_q updates only for ADD/SUB; logic ops write of_q=0 (mirrors ALU).
- Reset mid-operation: abort immediately; no rf_we is issued even if reset coincides with WB, since reset has priority over all state outputs.
- instr_valid outside IDLE is ignored; the word is not captured.

Optional Feature:
- Macro: R_INSTR_OF_TRAP_EN.
- Defined: ADD/SUB with alu_of=1 in EXEC suppresses rf_we in WB, pulses an extra output ov_trap (1 bit, reset 0) with done, and holds of_q=1.
- Undefined: ov_trap port absent; overflowing results are written back normally and only of_q records the overflow.

Decomposition:
- Package r_instr_pkg: ALU opcode constants (ALU_AND..ALU_SLL, 3-bit); funct constants (6-bit); OP_RTYPE=6'b000000; FSM state enum (IDLE, DECODE, EXEC, WB, 2-bit).
- Sub-module r_instr_decode: combinational instr -> {alu_op, illegal, wr_en_ok}. Instanced once; keeps the FSM file purely sequential.

Test Plan:
- rs=1, rt=2, rd=3, funct ADD; ALU returns 0x00000005 -> alu_op=100 in DECODE/EXEC; rf_we=1, rf_wa=3, rf_wd=5 at cycle 4; done pulse; zf_q=0.
- SUB with alu_f=0, alu_zf=1 -> zf_q=1; rf_wd=0 written to rd.
- instr=0x8C000000 (op!=0) -> no rf_we; illegal and done pulse at cycle 4; flags retained from the previous instruction.
- ADD with rd=0 -> rf_we stays 0 throughout; done pulses.
- Assert rst during EXEC -> next cycle IDLE, instr_ready=1; no rf_we ever observed. Back-to-back instr_valid held high -> accepted only every 4th cycle.
- With R_INSTR_OF_TRAP_EN: ADD with alu_of=1 -> ov_trap=1, rf_we=0, of_q=1. Without the macro: rf_we=1, of_q=1.
